hd_demux3_buf: RTL and testbench



---
 rtl/hd_demux3_pkg.sv | 25 ++
 rtl/hd_demux3_lane_fifo.sv | 70 +++++++
 rtl/hd_demux3_buf.sv | 71 +++++++
 tb/tb_hd_demux3_buf.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hd_demux3_pkg.sv
// Shared types and helpers for the 1:3 demux with per-lane buffering.
// Lane select encoding matches the 3:1 select mux of the HD cell set.
package hd_demux3_pkg;

  typedef logic [1:0] lane_t;

  localparam lane_t LANE0 = 2'd0;
  localparam lane_t LANE1 = 2'd1;
  localparam lane_t LANE2 = 2'd2;

  // SL1 dominates, so SL0 is a don't-care whenever lane 2 is selected.
  function automatic lane_t sel_to_lane(input logic sl1, input logic sl0);
    if (sl1)
      return LANE2;
    else if (sl0)
      return LANE1;
    else
      return LANE0;
  endfunction

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/hd_demux3_lane_fifo.sv
// One output lane: DEPTH-entry FIFO with valid/ready on both sides,
// zero-forced output data and a saturating accepted-transfer counter.
module hd_demux3_lane_fifo
  import hd_demux3_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  output logic          full,
  output logic [W-1:0]  z,
  output logic          z_vld,
  input  logic          z_rdy,
  input  logic          clr,
  output logic [CW-1:0] cnt
);

  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW:0] FULL_OCC = (PW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [PW:0]   occ;
  logic          pop;

  assign full  = (occ == FULL_OCC);
  assign z_vld = (occ != '0);
  assign pop   = z_vld & z_rdy;
  assign z     = z_vld ? mem[rp] : '0;

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push)
      mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      occ <= '0;
    end else begin
      if (push)
        wp <= wp + 1'b1;
      if (pop)
        rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Clear wins over a same-cycle accept; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (push && (cnt != {CW{1'b1}}))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/hd_demux3_buf.sv
// Splits one time-multiplexed input stream into three buffered lanes,
// selected by SL1/SL0 with the same encoding as the 3:1 select mux.
module hd_demux3_buf
  import hd_demux3_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  parameter int CW    = 8
) (
  input  logic          CK,
  input  logic          RN,
  input  logic [W-1:0]  A,
  input  logic          A_VLD,
  output logic          A_RDY,
  input  logic          SL0,
  input  logic          SL1,
  output logic [W-1:0]  Z0,
  output logic [W-1:0]  Z1,
  output logic [W-1:0]  Z2,
  output logic          Z0_VLD,
  output logic          Z1_VLD,
  output logic          Z2_VLD,
  input  logic          Z0_RDY,
  input  logic          Z1_RDY,
  input  logic          Z2_RDY,
  input  logic          CLR,
  output logic [CW-1:0] CNT0,
  output logic [CW-1:0] CNT1,
  output logic [CW-1:0] CNT2
);

  lane_t      sel;
  logic [2:0] full;
  logic [2:0] push;

  assign sel = sel_to_lane(SL1, SL0);

  // Ready depends only on the selected lane's registered fullness, never on
  // downstream ready, so a pop does not open space until the next cycle.
  always_comb begin
    A_RDY = 1'b0;
    case (sel)
      LANE0:   A_RDY = !full[0];
      LANE1:   A_RDY = !full[1];
      default: A_RDY = !full[2];
    endcase
  end

  assign push[0] = A_VLD & A_RDY & (sel == LANE0);
  assign push[1] = A_VLD & A_RDY & (sel == LANE1);
  assign push[2] = A_VLD & A_RDY & (sel == LANE2);

  hd_demux3_lane_fifo #(.W(W), .DEPTH(DEPTH), .CW(CW)) u_lane0 (
    .clk(CK), .rst_n(RN), .push(push[0]), .din(A), .full(full[0]),
    .z(Z0), .z_vld(Z0_VLD), .z_rdy(Z0_RDY), .clr(CLR), .cnt(CNT0)
  );

  hd_demux3_lane_fifo #(.W(W), .DEPTH(DEPTH), .CW(CW)) u_lane1 (
    .clk(CK), .rst_n(RN), .push(push[1]), .din(A), .full(full[1]),
    .z(Z1), .z_vld(Z1_VLD), .z_rdy(Z1_RDY), .clr(CLR), .cnt(CNT1)
  );

  hd_demux3_lane_fifo #(.W(W), .DEPTH(DEPTH), .CW(CW)) u_lane2 (
    .clk(CK), .rst_n(RN), .push(push[2]), .din(A), .full(full[2]),
    .z(Z2), .z_vld(Z2_VLD), .z_rdy(Z2_RDY), .clr(CLR), .cnt(CNT2)
  );

  a_sel_known: assert property (@(posedge CK) disable iff (!RN)
    A_VLD |-> !$isunknown({SL1, SL0}));

endmodule

// File: tb/tb_hd_demux3_buf.sv
// Directed and randomized checks of hd_demux3_buf against a queue-based
// model of three independent DEPTH-entry lanes with saturating counters.
module tb_hd_demux3_buf;

  localparam int W     = 8;
  localparam int DEPTH = 2;
  localparam int CW    = 8;
  localparam int CMAX  = (1 << CW) - 1;

  logic          CK = 1'b0;
  logic          RN = 1'b0;
  logic [W-1:0]  A = '0;
  logic          A_VLD = 1'b0;
  logic          A_RDY;
  logic          SL0 = 1'b0;
  logic          SL1 = 1'b0;
  logic [W-1:0]  Z0, Z1, Z2;
  logic          Z0_VLD, Z1_VLD, Z2_VLD;
  logic          Z0_RDY = 1'b0;
  logic          Z1_RDY = 1'b0;
  logic          Z2_RDY = 1'b0;
  logic          CLR = 1'b0;
  logic [CW-1:0] CNT0, CNT1, CNT2;

  int total = 0;
  int bad   = 0;

  int mq [3][$];
  int mcnt [3];

  hd_demux3_buf #(.W(W), .DEPTH(DEPTH), .CW(CW)) dut (
    .CK(CK), .RN(RN), .A(A), .A_VLD(A_VLD), .A_RDY(A_RDY),
    .SL0(SL0), .SL1(SL1),
    .Z0(Z0), .Z1(Z1), .Z2(Z2),
    .Z0_VLD(Z0_VLD), .Z1_VLD(Z1_VLD), .Z2_VLD(Z2_VLD),
    .Z0_RDY(Z0_RDY), .Z1_RDY(Z1_RDY), .Z2_RDY(Z2_RDY),
    .CLR(CLR), .CNT0(CNT0), .CNT1(CNT1), .CNT2(CNT2)
  );

  always #5 CK = ~CK;

  function automatic int dut_z(int n);
    return (n == 0) ? int'(Z0) : (n == 1) ? int'(Z1) : int'(Z2);
  endfunction

  function automatic int dut_vld(int n);
    return (n == 0) ? int'(Z0_VLD) : (n == 1) ? int'(Z1_VLD) : int'(Z2_VLD);
  endfunction

  function automatic int dut_cnt(int n);
    return (n == 0) ? int'(CNT0) : (n == 1) ? int'(CNT1) : int'(CNT2);
  endfunction

  function automatic int sel_lane();
    return SL1 ? 2 : (SL0 ? 1 : 0);
  endfunction

  function automatic int exp_rdy();
    return (mq[sel_lane()].size() < DEPTH) ? 1 : 0;
  endfunction

  function automatic int exp_z(int n);
    return (mq[n].size() > 0) ? mq[n][0] : 0;
  endfunction

  function automatic int exp_vld(int n);
    return (mq[n].size() > 0) ? 1 : 0;
  endfunction

  task automatic set_rdy(input logic [2:0] r);
    {Z2_RDY, Z1_RDY, Z0_RDY} = r;
  endtask

  task automatic set_sel(input int lane);
    SL1 = (lane == 2);
    SL0 = (lane == 1) ? 1'b1 : ((lane == 2) ? 1'($urandom_range(0, 1)) : 1'b0);
  endtask

  task automatic model_clear();
    for (int n = 0; n < 3; n++) begin
      mq[n].delete();
      mcnt[n] = 0;
    end
  endtask

  // Advance one clock: decide accept/pops from pre-edge state, then apply.
  task automatic tick();
    int lane;
    bit acc;
    bit [2:0] pop;
    bit [2:0] rdy;
    lane = sel_lane();
    acc  = A_VLD && (mq[lane].size() < DEPTH);
    rdy  = {Z2_RDY, Z1_RDY, Z0_RDY};
    for (int n = 0; n < 3; n++)
      pop[n] = (mq[n].size() > 0) && rdy[n];
    @(posedge CK);
    for (int n = 0; n < 3; n++)
      if (pop[n]) void'(mq[n].pop_front());
    if (acc) mq[lane].push_back(int'(A));
    for (int n = 0; n < 3; n++) begin
      if (CLR) mcnt[n] = 0;
      else if (acc && lane == n && mcnt[n] < CMAX) mcnt[n]++;
    end
    #2;
  endtask

  task automatic test_reset();
    #12;
    for (int s = 0; s < 4; s++) begin
      {SL1, SL0} = 2'(s);
      #1;
      total++;
      if (A_RDY !== 1'b1) begin
        bad++;
        $display("[TB] FAIL reset_a_rdy sel=%0d: got %0b want 1", s, A_RDY);
      end
    end
    for (int n = 0; n < 3; n++) begin
      total++;
      if (dut_vld(n) != 0 || dut_z(n) != 0 || dut_cnt(n) != 0) begin
        bad++;
        $display("[TB] FAIL reset_lane%0d: got vld=%0d z=%0h cnt=%0d want 0/0/0",
                 n, dut_vld(n), dut_z(n), dut_cnt(n));
      end
    end
    RN = 1'b1;
    model_clear();
    @(posedge CK);
    #2;
  endtask

  task automatic test_basic();
    int vals [3] = '{8'h11, 8'h22, 8'h33};
    set_rdy(3'b111);
    A_VLD = 1'b1;
    for (int n = 0; n < 3; n++) begin
      A = W'(vals[n]);
      set_sel(n);
      tick();
      total++;
      if (dut_vld(n) != 1 || dut_z(n) != vals[n]) begin
        bad++;
        $display("[TB] FAIL basic_lane%0d: got vld=%0d z=%0h want 1/%0h",
                 n, dut_vld(n), dut_z(n), vals[n]);
      end
      if (n > 0) begin
        total++;
        if (dut_vld(n - 1) != 0) begin
          bad++;
          $display("[TB] FAIL basic_one_cycle_lane%0d: got vld=%0d want 0", n - 1, dut_vld(n - 1));
        end
      end
    end
    A_VLD = 1'b0;
    tick();
    for (int n = 0; n < 3; n++) begin
      total++;
      if (dut_cnt(n) != 1 || dut_vld(n) != 0) begin
        bad++;
        $display("[TB] FAIL basic_cnt%0d: got cnt=%0d vld=%0d want 1/0", n, dut_cnt(n), dut_vld(n));
      end
    end
  endtask

  task automatic test_backpressure();
    set_rdy(3'b101);
    A_VLD = 1'b1;
    set_sel(1);
    A = 8'hA0; tick();
    A = 8'hA1; tick();
    A = 8'hA2;
    #1;
    total++;
    if (A_RDY !== 1'b0) begin
      bad++;
      $display("[TB] FAIL bp_full_lane1: got a_rdy=%0b want 0", A_RDY);
    end
    set_sel(0);
    #1;
    total++;
    if (A_RDY !== 1'b1) begin
      bad++;
      $display("[TB] FAIL bp_other_lane: got a_rdy=%0b want 1", A_RDY);
    end
    A_VLD = 1'b0;
    set_sel(1);
    set_rdy(3'b111);
    #1;
    total++;
    if (Z1 !== 8'hA0 || A_RDY !== 1'b0) begin
      bad++;
      $display("[TB] FAIL bp_pop_cycle: got z1=%0h a_rdy=%0b want a0/0", Z1, A_RDY);
    end
    tick();
    total++;
    if (Z1 !== 8'hA1 || A_RDY !== 1'b1 || exp_z(1) != 8'hA1) begin
      bad++;
      $display("[TB] FAIL bp_after_pop: got z1=%0h a_rdy=%0b want a1/1", Z1, A_RDY);
    end
    tick();
    total++;
    if (Z1_VLD !== 1'b0) begin
      bad++;
      $display("[TB] FAIL bp_drained: got z1_vld=%0b want 0", Z1_VLD);
    end
  endtask

  task automatic test_push_pop();
    set_rdy(3'b110);
    set_sel(0);
    A_VLD = 1'b1;
    A = 8'h54;
    tick();
    Z0_RDY = 1'b1;
    A = 8'h55;
    tick();
    total++;
    if (Z0 !== 8'h55 || Z0_VLD !== 1'b1 || A_RDY !== 1'b1) begin
      bad++;
      $display("[TB] FAIL pushpop_55: got z0=%0h vld=%0b a_rdy=%0b want 55/1/1", Z0, Z0_VLD, A_RDY);
    end
    for (int i = 0; i < 10; i++) begin
      A = W'(i);
      tick();
      total++;
      if (int'(Z0) != i || Z0_VLD !== 1'b1 || exp_z(0) != i) begin
        bad++;
        $display("[TB] FAIL pushpop_wrap%0d: got z0=%0h vld=%0b want %0h/1", i, Z0, Z0_VLD, i);
      end
    end
    A_VLD = 1'b0;
    tick();
    total++;
    if (Z0_VLD !== 1'b0 || Z0 !== '0) begin
      bad++;
      $display("[TB] FAIL pushpop_drain: got vld=%0b z0=%0h want 0/0", Z0_VLD, Z0);
    end
  endtask

  task automatic test_saturation();
    set_rdy(3'b111);
    set_sel(2);
    A_VLD = 1'b1;
    for (int i = 0; i < 260; i++) begin
      A = W'($urandom);
      tick();
    end
    total++;
    if (CNT2 !== 8'd255 || mcnt[2] != CMAX) begin
      bad++;
      $display("[TB] FAIL sat_cnt2: got %0d want 255", CNT2);
    end
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    total++;
    if (CNT2 !== '0 || CNT0 !== '0 || CNT1 !== '0) begin
      bad++;
      $display("[TB] FAIL clr_priority: got cnt=%0d/%0d/%0d want 0/0/0", CNT0, CNT1, CNT2);
    end
    A_VLD = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    set_rdy(3'b000);
    A_VLD = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_sel((i < 2) ? 0 : 2);
      A = W'(8'hC0 + i);
      tick();
    end
    A_VLD = 1'b0;
    total++;
    if (Z0_VLD !== 1'b1 || Z2_VLD !== 1'b1 || Z0 !== 8'hC0 || Z2 !== 8'hC2) begin
      bad++;
      $display("[TB] FAIL ares_prefill: got z0=%0h z2=%0h want c0/c2", Z0, Z2);
    end
    #1;
    RN = 1'b0;
    #1;
    for (int n = 0; n < 3; n++) begin
      total++;
      if (dut_vld(n) != 0 || dut_z(n) != 0 || dut_cnt(n) != 0) begin
        bad++;
        $display("[TB] FAIL ares_lane%0d: got vld=%0d z=%0h cnt=%0d want 0/0/0",
                 n, dut_vld(n), dut_z(n), dut_cnt(n));
      end
    end
    model_clear();
    #3;
    RN = 1'b1;
    tick();
    for (int s = 0; s < 4; s++) begin
      {SL1, SL0} = 2'(s);
      #1;
      total++;
      if (A_RDY !== 1'b1) begin
        bad++;
        $display("[TB] FAIL ares_release_rdy sel=%0d: got %0b want 1", s, A_RDY);
      end
    end
  endtask

  task automatic test_random();
    bit hold;
    hold = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (!hold) begin
        A     = W'($urandom);
        A_VLD = ($urandom_range(0, 9) < 7);
        {SL1, SL0} = 2'($urandom);
      end
      set_rdy(3'($urandom));
      CLR = ($urandom_range(0, 499) == 0);
      #1;
      total++;
      if (int'(A_RDY) != exp_rdy()) begin
        bad++;
        $display("[TB] FAIL rand_a_rdy c=%0d: got %0b want %0d", c, A_RDY, exp_rdy());
      end
      for (int n = 0; n < 3; n++) begin
        total++;
        if (dut_vld(n) != exp_vld(n) || dut_z(n) != exp_z(n) || dut_cnt(n) != mcnt[n]) begin
          bad++;
          $display("[TB] FAIL rand_lane%0d c=%0d: got vld=%0d z=%0h cnt=%0d want %0d/%0h/%0d",
                   n, c, dut_vld(n), dut_z(n), dut_cnt(n), exp_vld(n), exp_z(n), mcnt[n]);
        end
      end
      hold = A_VLD && (exp_rdy() == 0);
      tick();
    end
    A_VLD = 1'b0;
    CLR   = 1'b0;
    set_rdy(3'b111);
    tick();
    tick();
    tick();
    for (int n = 0; n < 3; n++) begin
      total++;
      if (dut_vld(n) != 0 || mq[n].size() != 0) begin
        bad++;
        $display("[TB] FAIL rand_drain%0d: got vld=%0d want 0", n, dut_vld(n));
      end
    end
  endtask

  initial begin
    $display("[TB] starting hd_demux3_buf bench");
    test_reset();
    test_basic();
    test_backpressure();
    test_push_pop();
    test_saturation();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
